// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory stage: op and size codes,
// and the FSM state type used by the top level.
package lsu_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_LOADU = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } lsu_state_e;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RIDX = 5;

    // True for ops that return data to the register file.
    function automatic logic op_is_load(input mem_op_e op);
        return (op == MEM_LOAD) || (op == MEM_LOADU);
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory port: single-outstanding request/acknowledge bus.
// The LSU is the master; the memory (or its model) is the slave.
interface lsu_mem_stage_if;

    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [3:0]  dBe;
    logic [31:0] dWdata;
    logic        dAck;
    logic [31:0] dRdata;

    modport master (
        output dReq,
        output dWe,
        output dAddr,
        output dBe,
        output dWdata,
        input  dAck,
        input  dRdata
    );

    modport slave (
        input  dReq,
        input  dWe,
        input  dAddr,
        input  dBe,
        input  dWdata,
        output dAck,
        output dRdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: alignment check, byte enables and store
// replication for the op on the latch, plus extract/extend of load data
// for the op captured at issue.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] store_data,
    output logic        aligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,

    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_signed,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Request side: which lanes are touched and how store data is spread.
    always_comb begin
        aligned = 1'b0;
        be      = '0;
        wdata   = '0;
        case (mem_size_e'(req_size))
            SZ_B: begin
                aligned = 1'b1;
                be      = 4'b0001 << req_addr_lo;
                wdata   = {4{store_data[7:0]}};
            end
            SZ_H: begin
                aligned = ~req_addr_lo[0];
                be      = 4'b0011 << {req_addr_lo[1], 1'b0};
                wdata   = {2{store_data[15:0]}};
            end
            SZ_W: begin
                aligned = (req_addr_lo == 2'b00);
                be      = 4'b1111;
                wdata   = store_data;
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
    end

    // Response side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = rdata >> {ld_addr_lo, 3'b000};
        ld_data = shifted;
        case (mem_size_e'(ld_size))
            SZ_B:    ld_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access pipeline stage. Issues one data-memory transaction at a
// time, holds the upstream latch via stall while it is in flight, and
// produces writeback pulses for loads and register-writing ALU ops.
module lsu_mem_stage
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      memOp,
    input  logic [1:0]      memSize,
    input  logic [31:0]     addr,
    input  logic [31:0]     storeData,
    input  logic [4:0]      rd,
    input  logic            aluToReg,
    output logic            stall,
    lsu_mem_stage_if.master dmem,
    output logic            wbValid,
    output logic [4:0]      wbRd,
    output logic [31:0]     wbData,
    output logic            misalign,
    output logic [31:0]     faultAddr
);

    lsu_state_e  state_q, state_d;

    logic        dreq_q, dreq_d;
    logic        dwe_q, dwe_d;
    logic [31:0] daddr_q, daddr_d;
    logic [3:0]  dbe_q, dbe_d;
    logic [31:0] dwdata_q, dwdata_d;

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    // Attributes of the op in flight, needed when the response returns.
    logic        is_load_q, is_load_d;
    logic        ld_signed_q, ld_signed_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic [1:0]  ld_addr_lo_q, ld_addr_lo_d;
    logic [4:0]  ld_rd_q, ld_rd_d;

    logic        stall_c;
    mem_op_e     op;
    logic        aligned;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld_data;

    assign op = mem_op_e'(memOp);

    lsu_lane_align u_lane (
        .req_size    (memSize),
        .req_addr_lo (addr[1:0]),
        .store_data  (storeData),
        .aligned     (aligned),
        .be          (be),
        .wdata       (wdata),
        .ld_size     (ld_size_q),
        .ld_addr_lo  (ld_addr_lo_q),
        .ld_signed   (ld_signed_q),
        .rdata       (dmem.dRdata),
        .ld_data     (ld_data)
    );

    // Next-state, bus, writeback and fault logic.
    always_comb begin
        state_d      = state_q;
        stall_c      = 1'b0;
        dreq_d       = dreq_q;
        dwe_d        = dwe_q;
        daddr_d      = daddr_q;
        dbe_d        = dbe_q;
        dwdata_d     = dwdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        misalign_d   = 1'b0;
        fault_addr_d = fault_addr_q;
        is_load_d    = is_load_q;
        ld_signed_d  = ld_signed_q;
        ld_size_d    = ld_size_q;
        ld_addr_lo_d = ld_addr_lo_q;
        ld_rd_d      = ld_rd_q;

        case (state_q)
            IDLE: begin
                if (op != MEM_NONE) begin
                    if (aligned) begin
                        stall_c      = 1'b1;
                        dreq_d       = 1'b1;
                        dwe_d        = (op == MEM_STORE);
                        daddr_d      = {addr[31:2], 2'b00};
                        dbe_d        = be;
                        dwdata_d     = wdata;
                        is_load_d    = op_is_load(op);
                        ld_signed_d  = (op == MEM_LOAD);
                        ld_size_d    = memSize;
                        ld_addr_lo_d = addr[1:0];
                        ld_rd_d      = rd;
                        state_d      = BUSY;
                    end else begin
                        misalign_d   = 1'b1;
                        fault_addr_d = addr;
                    end
                end else if (aluToReg && (rd != '0)) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd;
                    wb_data_d  = addr;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dmem.dAck) begin
                    dreq_d  = 1'b0;
                    state_d = RESP;
                    if (is_load_q && (ld_rd_q != '0)) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ld_rd_q;
                        wb_data_d  = ld_data;
                    end
                end
            end
            // The latch still shows the op just serviced; releasing stall
            // here lets it advance once without being issued again.
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dreq_q       <= 1'b0;
            dwe_q        <= 1'b0;
            daddr_q      <= '0;
            dbe_q        <= '0;
            dwdata_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            misalign_q   <= 1'b0;
            fault_addr_q <= '0;
            is_load_q    <= 1'b0;
            ld_signed_q  <= 1'b0;
            ld_size_q    <= '0;
            ld_addr_lo_q <= '0;
            ld_rd_q      <= '0;
        end else begin
            state_q      <= state_d;
            dreq_q       <= dreq_d;
            dwe_q        <= dwe_d;
            daddr_q      <= daddr_d;
            dbe_q        <= dbe_d;
            dwdata_q     <= dwdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            misalign_q   <= misalign_d;
            fault_addr_q <= fault_addr_d;
            is_load_q    <= is_load_d;
            ld_signed_q  <= ld_signed_d;
            ld_size_q    <= ld_size_d;
            ld_addr_lo_q <= ld_addr_lo_d;
            ld_rd_q      <= ld_rd_d;
        end
    end

    assign stall       = stall_c & ~reset;
    assign dmem.dReq   = dreq_q;
    assign dmem.dWe    = dwe_q;
    assign dmem.dAddr  = daddr_q;
    assign dmem.dBe    = dbe_q;
    assign dmem.dWdata = dwdata_q;
    assign wbValid     = wb_valid_q;
    assign wbRd        = wb_rd_q;
    assign wbData      = wb_data_q;
    assign misalign    = misalign_q;
    assign faultAddr   = fault_addr_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: emulates the upstream op latch and a data
// memory with programmable ack delay, and compares observed events
// against a directed table and a transaction-level reference model.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memOp;
    logic [1:0]  memSize;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic [4:0]  rd;
    logic        aluToReg;
    logic        stall;
    logic        wbValid;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        misalign;
    logic [31:0] faultAddr;

    lsu_mem_stage_if dmem ();

    lsu_mem_stage dut (
        .clk       (clk),
        .reset     (reset),
        .memOp     (memOp),
        .memSize   (memSize),
        .addr      (addr),
        .storeData (storeData),
        .rd        (rd),
        .aluToReg  (aluToReg),
        .stall     (stall),
        .dmem      (dmem),
        .wbValid   (wbValid),
        .wbRd      (wbRd),
        .wbData    (wbData),
        .misalign  (misalign),
        .faultAddr (faultAddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        alu;
        int unsigned dly;
        logic [31:0] rdata;
    } op_t;

    typedef struct { int unsigned idx; logic [4:0] rd; logic [31:0] data; } wb_ev_t;
    typedef struct { int unsigned idx; logic [31:0] a; } flt_ev_t;
    typedef struct { int unsigned idx; logic we; logic [31:0] a; logic [3:0] be; logic [31:0] wd; } req_ev_t;

    typedef struct {
        op_t         o;
        int unsigned x_stall;
        logic        x_wb;
        logic [31:0] x_wbdata;
        logic        x_flt;
        logic [31:0] x_faddr;
        logic        x_req;
        logic        x_we;
        logic [31:0] x_daddr;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
    } vec_t;

    op_t         seq[$];
    wb_ev_t      obs_wb[$],  exp_wb[$];
    flt_ev_t     obs_flt[$], exp_flt[$];
    req_ev_t     obs_req[$], exp_req[$];
    int unsigned obs_stall[$], exp_stall[$];
    int unsigned req_cycles;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] sd, input logic [4:0] r, input logic alu,
                               input int unsigned dly, input logic [31:0] rdata);
        op_t t;
        t.op = op; t.sz = sz; t.a = a; t.sd = sd; t.rd = r; t.alu = alu; t.dly = dly; t.rdata = rdata;
        return t;
    endfunction

    // Reference model: expected events for the whole op sequence, derived
    // from sizes in bytes and plain shifts rather than bit-level encodings.
    task automatic build_expect();
        exp_wb.delete(); exp_flt.delete(); exp_req.delete(); exp_stall.delete();
        for (int i = 0; i < seq.size(); i++) begin
            op_t o = seq[i];
            int unsigned nb = 1 << o.sz;
            int unsigned off = o.a % 4;
            bit ok = (o.sz != 2'd3) && (off % nb == 0);
            if (o.op == 2'd0) begin
                exp_stall.push_back(0);
                if (o.alu && o.rd != 0) exp_wb.push_back('{i + 1, o.rd, o.a});
            end else if (!ok) begin
                exp_stall.push_back(0);
                exp_flt.push_back('{i + 1, o.a});
            end else begin
                logic [31:0] wd, val, mask;
                logic [3:0]  be4;
                be4 = 4'(((1 << nb) - 1) << off);
                for (int b = 0; b < 4; b++) wd[8*b +: 8] = o.sd[8*(b % nb) +: 8];
                exp_stall.push_back(o.dly + 1);
                exp_req.push_back('{i, o.op == 2'd2, o.a & 32'hFFFF_FFFC, be4, wd});
                if (o.op != 2'd2 && o.rd != 0) begin
                    val  = o.rdata >> (8 * off);
                    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
                    val  = val & mask;
                    if (o.op == 2'd1 && val[8*nb-1]) val = val | ~mask;
                    exp_wb.push_back('{i, o.rd, val});
                end
            end
        end
    endtask

    // Drives seq through an emulated latch (advances only when stall is
    // low) and a memory that acks after dly request cycles.
    // Entered and left at posedge + 1.
    task automatic run_seq(input bit spur);
        int unsigned li = 0, reqcnt = 0, held = 0;
        logic st;
        logic        s_we;
        logic [31:0] s_a, s_wd;
        logic [3:0]  s_be;
        obs_wb.delete(); obs_flt.delete(); obs_req.delete(); obs_stall.delete();
        req_cycles = 0;
        foreach (seq[i]) obs_stall.push_back(0);
        while (li < seq.size()) begin
            memOp = seq[li].op; memSize = seq[li].sz; addr = seq[li].a;
            storeData = seq[li].sd; rd = seq[li].rd; aluToReg = seq[li].alu;
            if (dmem.dReq) begin
                reqcnt++;
                req_cycles++;
                if (reqcnt == 1) begin
                    s_we = dmem.dWe; s_a = dmem.dAddr; s_be = dmem.dBe; s_wd = dmem.dWdata;
                end else begin
                    chk("dWe stable", {31'b0, dmem.dWe}, {31'b0, s_we});
                    chk("dAddr stable", dmem.dAddr, s_a);
                    chk("dBe stable", {28'b0, dmem.dBe}, {28'b0, s_be});
                    chk("dWdata stable", dmem.dWdata, s_wd);
                end
                dmem.dAck   = (reqcnt == seq[li].dly);
                dmem.dRdata = dmem.dAck ? seq[li].rdata : $urandom();
            end else begin
                reqcnt      = 0;
                dmem.dAck   = spur ? ($urandom_range(0, 3) == 0) : 1'b0;
                dmem.dRdata = $urandom();
            end
            #1;
            st = stall;
            if (dmem.dReq && dmem.dAck)
                obs_req.push_back('{li, dmem.dWe, dmem.dAddr, dmem.dBe, dmem.dWdata});
            if (wbValid)  obs_wb.push_back('{li, wbRd, wbData});
            if (misalign) obs_flt.push_back('{li, faultAddr});
            if (st) obs_stall[li]++;
            @(posedge clk);
            #1;
            if (!st) begin
                li++;
                held = 0;
            end else begin
                held++;
                if (held > 64) begin
                    chk("stall bound", 32'(held), 32'd64);
                    reset = 1'b1;
                    #1;
                    reset = 1'b0;
                    @(posedge clk);
                    #1;
                    break;
                end
            end
        end
        memOp = 2'd0; aluToReg = 1'b0; dmem.dAck = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, " wb count"}, 32'(obs_wb.size()), 32'(exp_wb.size()));
        for (int i = 0; i < exp_wb.size() && i < obs_wb.size(); i++) begin
            chk({tag, " wb slot"}, 32'(obs_wb[i].idx), 32'(exp_wb[i].idx));
            chk({tag, " wbRd"}, {27'b0, obs_wb[i].rd}, {27'b0, exp_wb[i].rd});
            chk({tag, " wbData"}, obs_wb[i].data, exp_wb[i].data);
        end
        chk({tag, " fault count"}, 32'(obs_flt.size()), 32'(exp_flt.size()));
        for (int i = 0; i < exp_flt.size() && i < obs_flt.size(); i++) begin
            chk({tag, " fault slot"}, 32'(obs_flt[i].idx), 32'(exp_flt[i].idx));
            chk({tag, " faultAddr"}, obs_flt[i].a, exp_flt[i].a);
        end
        if (exp_flt.size() > 0)
            chk({tag, " faultAddr held"}, faultAddr, exp_flt[exp_flt.size() - 1].a);
        chk({tag, " req count"}, 32'(obs_req.size()), 32'(exp_req.size()));
        for (int i = 0; i < exp_req.size() && i < obs_req.size(); i++) begin
            chk({tag, " req slot"}, 32'(obs_req[i].idx), 32'(exp_req[i].idx));
            chk({tag, " dWe"}, {31'b0, obs_req[i].we}, {31'b0, exp_req[i].we});
            chk({tag, " dAddr"}, obs_req[i].a, exp_req[i].a);
            chk({tag, " dBe"}, {28'b0, obs_req[i].be}, {28'b0, exp_req[i].be});
            if (exp_req[i].we) chk({tag, " dWdata"}, obs_req[i].wd, exp_req[i].wd);
        end
        for (int i = 0; i < exp_stall.size() && i < obs_stall.size(); i++)
            chk({tag, " stall cycles"}, 32'(obs_stall[i]), 32'(exp_stall[i]));
    endtask

    vec_t tbl[13];
    op_t  pad;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pad = mk(2'd0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1, 32'h0);

        //            op     sz     addr          sdata         rd     alu   dly rdata          stall wb    wbdata         flt   faddr          req   we    daddr          be       wdata
        tbl[0]  = '{mk(2'd1, 2'd0, 32'h0000_0103, 32'h0,        5'd7,  1'b0, 2, 32'h80AA_55CC), 3, 1'b1, 32'hFFFF_FF80, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0100, 4'b1000, 32'h0};
        tbl[1]  = '{mk(2'd3, 2'd1, 32'h0000_0202, 32'h0,        5'd9,  1'b0, 1, 32'h8001_BEEF), 2, 1'b1, 32'h0000_8001, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0200, 4'b1100, 32'h0};
        tbl[2]  = '{mk(2'd2, 2'd0, 32'h0000_0301, 32'h5A,       5'd3,  1'b0, 3, 32'h0),         4, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0300, 4'b0010, 32'h5A5A_5A5A};
        tbl[3]  = '{mk(2'd1, 2'd2, 32'h0000_0402, 32'h0,        5'd4,  1'b0, 1, 32'h0),         0, 1'b0, 32'h0,         1'b1, 32'h0000_0402, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0};
        tbl[4]  = '{mk(2'd0, 2'd0, 32'h0000_1234, 32'h0,        5'd5,  1'b1, 1, 32'h0),         0, 1'b1, 32'h0000_1234, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         4'b0000, 32'h0};
        tbl[5]  = '{mk(2'd1, 2'd2, 32'h0000_0500, 32'h0,        5'd0,  1'b0, 1, 32'h1111_2222), 2, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0500, 4'b1111, 32'h0};
        tbl[6]  = '{mk(2'd0, 2'd0, 32'h0000_7777, 32'h0,        5'd0,  1'b1, 1, 32'h0),         0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         4'b0000, 32'h0};
        tbl[7]  = '{mk(2'd1, 2'd3, 32'h0000_0600, 32'h0,        5'd8,  1'b0, 1, 32'h0),         0, 1'b0, 32'h0,         1'b1, 32'h0000_0600, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0};
        tbl[8]  = '{mk(2'd3, 2'd1, 32'h0000_0603, 32'h0,        5'd8,  1'b0, 1, 32'h0),         0, 1'b0, 32'h0,         1'b1, 32'h0000_0603, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0};
        tbl[9]  = '{mk(2'd2, 2'd1, 32'h0000_0702, 32'hABCD_1234, 5'd1, 1'b0, 1, 32'h0),         2, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0700, 4'b1100, 32'h1234_1234};
        tbl[10] = '{mk(2'd2, 2'd2, 32'h0000_0800, 32'hDEAD_BEEF, 5'd2, 1'b0, 2, 32'h0),         3, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0800, 4'b1111, 32'hDEAD_BEEF};
        tbl[11] = '{mk(2'd0, 2'd0, 32'h0000_4444, 32'h0,        5'd5,  1'b0, 1, 32'h0),         0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         4'b0000, 32'h0};
        tbl[12] = '{mk(2'd1, 2'd1, 32'h0000_0900, 32'h0,        5'd6,  1'b0, 1, 32'h1234_F00D), 2, 1'b1, 32'hFFFF_F00D, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0900, 4'b0011, 32'h0};

        // Reset values, with an aligned load on the latch: stall stays low.
        reset = 1'b1;
        memOp = 2'd1; memSize = 2'd2; addr = 32'h40; storeData = 32'h0; rd = 5'd1; aluToReg = 1'b0;
        dmem.dAck = 1'b0; dmem.dRdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset dReq", {31'b0, dmem.dReq}, 32'd0);
        chk("reset dWe", {31'b0, dmem.dWe}, 32'd0);
        chk("reset dAddr", dmem.dAddr, 32'd0);
        chk("reset dBe", {28'b0, dmem.dBe}, 32'd0);
        chk("reset dWdata", dmem.dWdata, 32'd0);
        chk("reset wbValid", {31'b0, wbValid}, 32'd0);
        chk("reset wbRd", {27'b0, wbRd}, 32'd0);
        chk("reset wbData", wbData, 32'd0);
        chk("reset misalign", {31'b0, misalign}, 32'd0);
        chk("reset faultAddr", faultAddr, 32'd0);
        reset = 1'b0;
        memOp = 2'd0;

        // Directed table, each op followed by idle padding.
        for (int k = 0; k < 13; k++) begin
            seq = '{tbl[k].o, pad, pad};
            exp_wb.delete(); exp_flt.delete(); exp_req.delete(); exp_stall.delete();
            if (tbl[k].x_wb)
                exp_wb.push_back('{(tbl[k].o.op != 2'd0) ? 0 : 1, tbl[k].o.rd, tbl[k].x_wbdata});
            if (tbl[k].x_flt)
                exp_flt.push_back('{1, tbl[k].x_faddr});
            if (tbl[k].x_req)
                exp_req.push_back('{0, tbl[k].x_we, tbl[k].x_daddr, tbl[k].x_be, tbl[k].x_wdata});
            exp_stall = '{tbl[k].x_stall, 0, 0};
            run_seq(1'b0);
            compare_all($sformatf("tbl%0d", k));
        end

        // ALU writeback immediately followed by a load acked at once.
        seq = '{mk(2'd0, 2'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1, 32'h0),
                mk(2'd1, 2'd2, 32'h0000_1000, 32'h0, 5'd6, 1'b0, 1, 32'hCAFE_F00D),
                pad, pad};
        build_expect();
        run_seq(1'b0);
        compare_all("b2b");
        chk("b2b req cycles", 32'(req_cycles), 32'd1);
        chk("b2b wb pulses", 32'(obs_wb.size()), 32'd2);

        // Reset while BUSY, then a late ack.
        memOp = 2'd1; memSize = 2'd2; addr = 32'h40; rd = 5'd3; aluToReg = 1'b0; dmem.dAck = 1'b0;
        #1;
        chk("rst-mid stall issue", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        chk("rst-mid dReq busy", {31'b0, dmem.dReq}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst-mid dReq async", {31'b0, dmem.dReq}, 32'd0);
        chk("rst-mid stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        memOp = 2'd0;
        dmem.dAck = 1'b1;
        dmem.dRdata = 32'h1234_5678;
        #1;
        chk("rst-mid stall idle", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst-mid late ack wbValid", {31'b0, wbValid}, 32'd0);
        chk("rst-mid late ack dReq", {31'b0, dmem.dReq}, 32'd0);
        dmem.dAck = 1'b0;
        @(posedge clk);
        #1;
        chk("rst-mid wbValid after", {31'b0, wbValid}, 32'd0);
        seq = '{mk(2'd1, 2'd2, 32'h0000_0040, 32'h0, 5'd3, 1'b0, 1, 32'h0BAD_CAFE), pad, pad};
        build_expect();
        run_seq(1'b0);
        compare_all("post-reset");

        // Random back-to-back streams with stray acks outside BUSY.
        for (int r = 0; r < 3; r++) begin
            seq.delete();
            for (int i = 0; i < 50; i++) begin
                logic [31:0] a;
                logic [1:0]  sz;
                a  = $urandom();
                sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                seq.push_back(mk(2'($urandom_range(0, 3)), sz, a, $urandom(),
                                 ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                                 1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom()));
            end
            seq.push_back(pad);
            seq.push_back(pad);
            build_expect();
            run_seq(1'b1);
            compare_all($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory-access stage of the RISC-V pipeline: consumes the memory-op fields held by the execute pipeline latch, runs a single-outstanding request/acknowledge transaction on the data-memory port, and produces the writeback result. It is the source of the `stall` signal that freezes the upstream op latch while an access is in flight. Non-memory ops pass through to writeback without stalling.

## Interface
- No parameters. Data width fixed at 32, register index at 5.
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `memOp`  in  2  op from latch: 00 NONE, 01 LOAD (signed), 10 STORE, 11 LOADU (zero-extend).
- `memSize`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `addr`  in  32  ALU result, used as the effective address or the passthrough result.
- `storeData`  in  32  rs2 value for stores.
- `rd`  in  5  destination register.
- `aluToReg`  in  1  non-memory op writes `addr` to `rd`.
- `stall`  out  1  combinational; holds the upstream latch.
- `dReq`  out  1  data request (registered).
- `dWe`  out  1  1 = store.
- `dAddr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `dBe`  out  4  byte enables.
- `dWdata`  out  32  lane-replicated store data.
- `dAck`  in  1  single-cycle completion; `dRdata` valid in the same cycle.
- `dRdata`  in  32  load word.
- `wbValid`  out  1  one-cycle writeback pulse.
- `wbRd`  out  5  writeback register.
- `wbData`  out  32  writeback value.
- `misalign`  out  1  one-cycle fault pulse.
- `faultAddr`  out  32  faulting address, held until the next fault.

## Operation
- The FSM has three states: IDLE, BUSY, RESP.
- An op is *aligned* when one of these holds: byte; half with `addr[0]`=0; word with `addr[1:0]`=0. memSize 11 is never aligned.
- **IDLE, memOp≠NONE, aligned:**
  - `stall`=1.
  - Capture `addr`/`rd`/size/signedness.
  - Drive `dReq`, `dWe`, `dAddr`, `dBe`, `dWdata` from the next edge.
  - Go to BUSY.
- **IDLE, memOp≠NONE, misaligned:**
  - No request and no stall.
  - `misalign`=1 next cycle; `faultAddr`=`addr`.
  - No writeback.
- **IDLE, memOp=NONE, aluToReg=1, rd≠0:** next cycle `wbValid`=1, `wbData`=`addr`, `wbRd`=`rd`.
- **BUSY:**
  - `stall`=1 and `dReq`=1, with all `d*` outputs stable until `dAck`.
  - On `dAck`: go to RESP and deassert `dReq` at that edge.
  - On a load with rd≠0: register the extracted data and pulse `wbValid` in RESP.
- **RESP:**
  - `stall`=0, so the latch advances exactly once.
  - Next state is IDLE.
  - The op now on the latch outputs was already serviced. It is ignored for this one cycle, which prevents re-issue.
- **Byte enables:**
  - byte: `4'b0001<<addr[1:0]`.
  - half: `4'b0011<<{addr[1],1'b0}`.
  - word: `4'b1111`.
- **Store data:**
  - byte: `{4{storeData[7:0]}}`.
  - half: `{2{storeData[15:0]}}`.
  - word: `storeData`.
- **Load extract:** shift `dRdata` right by `8*addr[1:0]`, then take 8/16/32 bits. Sign-extend for LOAD, zero-extend for LOADU.
- Stores never produce `wbValid`.
- rd=0 never produces `wbValid`.

## Timing
- **Reset values:**
  - State IDLE.
  - `dReq`=0, `dWe`=0, `dAddr`=0, `dBe`=0, `dWdata`=0.
  - `wbValid`=0, `wbRd`=0, `wbData`=0.
  - `misalign`=0, `faultAddr`=0.
  - `stall`=0 whenever reset is high.
- **Memory-op latency:** op visible in cycle 0; `dReq` high from cycle 1; `dAck` in cycle k≥1; `wbValid` and `stall`=0 in cycle k+1. The minimum is 2 stall cycles.
- **Passthrough ops and faults:** 1-cycle latency, zero stall.
- `dAck` in IDLE or RESP is ignored.
- `dAck` coincident with the entry edge into BUSY is impossible, because `dReq` is still 0.
- **Reset mid-transaction:** `dReq` drops asynchronously, the FSM returns to IDLE, and a late `dAck` is ignored.

## Structure
- Package `lsu_pkg` holds:
  - memOp encodings (`MEM_NONE`, `MEM_LOAD`, `MEM_STORE`, `MEM_LOADU`).
  - memSize encodings (`SZ_B`, `SZ_H`, `SZ_W`).
  - The state enum (IDLE, BUSY, RESP).
- Sub-module `lsu_lane_align` (combinational) computes the alignment check, `dBe`, store replication and load extract/extend.
- Top level holds the FSM and registers.

## Test plan
- LOAD byte at addr 0x103, dRdata 0x80AA55CC, `dAck` after 2 cycles of `dReq` → `wbData`=0xFFFFFF80, one `wbValid`, 3 stall cycles, `dAddr`=0x100.
- LOADU half at 0x202, dRdata 0x8001BEEF → `wbData`=0x00008001, `dBe` observed 1100 during request.
- STORE byte 0x5A to 0x301 → `dWe`=1, `dBe`=0010, `dWdata`=0x5A5A5A5A, no `wbValid`; the latch advances only after `dAck`.
- Word LOAD at 0x402 → `misalign` pulse, `faultAddr`=0x402, no `dReq`, `stall` never 1.
- Back-to-back: ALU op rd=5 result 0x1234, then word LOAD with immediate ack → `wbValid` twice, the load is issued once only, and RESP does not re-issue.
- Reset asserted while BUSY, then `dAck` arrives → `dReq` low immediately, no `wbValid`, state IDLE.
